// File: rtl/pwm_dec_pkg.sv
// Shared types and helpers for the PWM speed decoder.
package pwm_dec_pkg;

    localparam int unsigned CODE_W = 3;

    typedef enum logic [1:0] {
        S_WAIT,
        S_HIGH,
        S_LOW
    } state_e;

    // Decision threshold between speed codes k-1 and k: midpoint of (k-1)/8 and k/8 of the period.
    function automatic int unsigned thresh(input int unsigned period, input int unsigned k);
        return ((2 * k - 1) * period) / 16;
    endfunction

endpackage

// File: rtl/pwm_speed_decoder_sync.sv
// Two-flop synchroniser for the PWM line followed by a rise/fall edge detector.
module pwm_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic lvl_q, lvl_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = din;
        lvl_d  = meta_q;
        prev_d = lvl_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            lvl_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            lvl_q  <= lvl_d;
            prev_q <= prev_d;
        end
    end

    assign lvl  = lvl_q;
    assign rise = lvl_q & ~prev_q;
    assign fall = ~lvl_q & prev_q;

endmodule

// File: rtl/pwm_speed_decoder.sv
// Recovers the commanded 3-bit speed code from the motor PWM line and flags line faults.
// Optional SPEED_FILTER_EN: commit a code only after two consecutive matching periods.
module pwm_speed_decoder
    import pwm_dec_pkg::*;
#(
    parameter int unsigned PERIOD  = 64,
    parameter int unsigned TOL     = 4,
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pwm_in,
    input  logic              fault_in,
    output logic [CODE_W-1:0] speed_code,
    output logic              code_valid,
    output logic              code_upd,
    output logic [CNT_W-1:0]  high_cnt,
    output logic              period_err,
    output logic              stuck_fault
);

    localparam logic [CNT_W-1:0] PMIN   = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] PMAX   = CNT_W'(PERIOD + TOL);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);
    localparam int unsigned      NCODES = (1 << CODE_W) - 1;

    logic lvl, rise, fall;

    pwm_in_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pwm_in),
        .lvl  (lvl),
        .rise (rise),
        .fall (fall)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              upd_q, upd_d;
    logic              perr_q, perr_d;
    logic              stuck_q, stuck_d;
`ifdef SPEED_FILTER_EN
    logic [CODE_W-1:0] cand_q, cand_d;
    logic              cand_vld_q, cand_vld_d;
`endif

    logic [CNT_W-1:0]  cnt_inc;
    logic [CODE_W-1:0] dec;
    logic              tmo;
    logic              period_ok;

    assign cnt_inc   = (cnt_q == TMO) ? cnt_q : cnt_q + 1'b1;
    // Fires once as the counter steps onto TIMEOUT; saturation keeps S_WAIT from re-firing.
    assign tmo       = (cnt_q == TMO_M1);
    assign period_ok = (cnt_q >= PMIN) && (cnt_q <= PMAX);

    always_comb begin
        dec = '0;
        for (int unsigned k = 1; k <= NCODES; k++) begin
            if (hcnt_q >= CNT_W'(thresh(PERIOD, k))) begin
                dec = dec + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc;
        hcnt_d     = hcnt_q;
        high_cnt_d = high_cnt_q;
        code_d     = code_q;
        valid_d    = valid_q;
        upd_d      = 1'b0;
        perr_d     = 1'b0;
        stuck_d    = stuck_q;
`ifdef SPEED_FILTER_EN
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
`endif
        if (fault_in) begin
            state_d = S_WAIT;
            cnt_d   = '0;
            hcnt_d  = '0;
            valid_d = 1'b0;
`ifdef SPEED_FILTER_EN
            cand_vld_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_WAIT: begin
                    if (rise) begin
                        state_d = S_HIGH;
                        cnt_d   = CNT_W'(1);
                    end else if (fall) begin
                        cnt_d = '0;
                    end else if (tmo) begin
                        if (lvl) begin
                            stuck_d = 1'b1;
                            valid_d = 1'b0;
                        end else begin
                            code_d  = '0;
                            valid_d = 1'b1;
                            upd_d   = 1'b1;
                        end
`ifdef SPEED_FILTER_EN
                        cand_vld_d = 1'b0;
`endif
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        hcnt_d  = cnt_q;
                        state_d = S_LOW;
                    end else if (tmo) begin
                        stuck_d = 1'b1;
                        valid_d = 1'b0;
                        state_d = S_WAIT;
`ifdef SPEED_FILTER_EN
                        cand_vld_d = 1'b0;
`endif
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_HIGH;
                        if (period_ok) begin
                            high_cnt_d = hcnt_q;
                            upd_d      = 1'b1;
                            stuck_d    = 1'b0;
`ifdef SPEED_FILTER_EN
                            if (cand_vld_q && (cand_q == dec)) begin
                                code_d  = dec;
                                valid_d = 1'b1;
                            end
                            cand_d     = dec;
                            cand_vld_d = 1'b1;
`else
                            code_d  = dec;
                            valid_d = 1'b1;
`endif
                        end else begin
                            perr_d = 1'b1;
`ifdef SPEED_FILTER_EN
                            cand_vld_d = 1'b0;
`endif
                        end
                    end else if (tmo) begin
                        // Line went quiet after a high phase: the motor has stopped.
                        code_d  = '0;
                        valid_d = 1'b1;
                        upd_d   = 1'b1;
                        state_d = S_WAIT;
`ifdef SPEED_FILTER_EN
                        cand_vld_d = 1'b0;
`endif
                    end
                end
                default: state_d = S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_WAIT;
            cnt_q      <= '0;
            hcnt_q     <= '0;
            high_cnt_q <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            upd_q      <= 1'b0;
            perr_q     <= 1'b0;
            stuck_q    <= 1'b0;
`ifdef SPEED_FILTER_EN
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            high_cnt_q <= high_cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            upd_q      <= upd_d;
            perr_q     <= perr_d;
            stuck_q    <= stuck_d;
`ifdef SPEED_FILTER_EN
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
`endif
        end
    end

    assign speed_code  = code_q;
    assign code_valid  = valid_q;
    assign code_upd    = upd_q;
    assign high_cnt    = high_cnt_q;
    assign period_err  = perr_q;
    assign stuck_fault = stuck_q;

endmodule

// File: tb/tb_pwm_speed_decoder.sv
// Bench for pwm_speed_decoder: table vectors, random periods against a period-level model,
// and hand sequences for timeouts, fault_in and reset. Honours SPEED_FILTER_EN.
module tb_pwm_speed_decoder;

    localparam int PERIOD  = 64;
    localparam int TOL     = 4;
    localparam int TIMEOUT = 256;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic             fault_in = 1'b0;
    logic [2:0]       speed_code;
    logic             code_valid;
    logic             code_upd;
    logic [CNT_W-1:0] high_cnt;
    logic             period_err;
    logic             stuck_fault;

    pwm_speed_decoder #(
        .PERIOD  (PERIOD),
        .TOL     (TOL),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .fault_in    (fault_in),
        .speed_code  (speed_code),
        .code_valid  (code_valid),
        .code_upd    (code_upd),
        .high_cnt    (high_cnt),
        .period_err  (period_err),
        .stuck_fault (stuck_fault)
    );

    always #5 clk = ~clk;

    // Expected output events: 0 = accepted period, 1 = period error, 2 = stop timeout.
    typedef struct {
        int kind;
        int code;
        int valid;
        int hcnt;
    } ev_t;

    typedef struct {
        int h;
        int p;
        int exp_code;
        bit exp_err;
    } vec_t;

    ev_t  q[$];
    vec_t tbl[12];
    int   n_checks = 0;
    int   n_errors = 0;

    // Period-level model of what the decoder reports.
    int m_code  = 0;
    int m_valid = 0;
    int m_hcnt  = 0;
`ifdef SPEED_FILTER_EN
    int m_cand     = 0;
    bit m_cand_vld = 1'b0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear_cand();
`ifdef SPEED_FILTER_EN
        m_cand_vld = 1'b0;
`endif
    endtask

    task automatic model_period(input int h, input int dec, input bit err);
        ev_t e;
        if (err) begin
            model_clear_cand();
            e.kind = 1;
        end else begin
`ifdef SPEED_FILTER_EN
            if (m_cand_vld && m_cand == dec) begin
                m_code  = dec;
                m_valid = 1;
            end
            m_cand     = dec;
            m_cand_vld = 1'b1;
`else
            m_code  = dec;
            m_valid = 1;
`endif
            m_hcnt = h;
            e.kind = 0;
        end
        e.code  = m_code;
        e.valid = m_valid;
        e.hcnt  = h;
        q.push_back(e);
    endtask

    function automatic int ref_code(input int h);
        int c;
        c = (16 * h + PERIOD) / (2 * PERIOD);  // nearest multiple of PERIOD/8, halves up
        return (c > 7) ? 7 : c;
    endfunction

    function automatic bit ref_err(input int p);
        int d;
        d = (p > PERIOD) ? p - PERIOD : PERIOD - p;
        return d > TOL;
    endfunction

    task automatic raw_period(input int h, input int p);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    // The event for this period appears once the following rising edge is seen.
    task automatic drive_period(input int h, input int p, input int dec, input bit err);
        raw_period(h, p);
        model_period(h, dec, err);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("event_drain", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!rst && (code_upd || period_err)) begin
            if (q.size() == 0) begin
                check("spurious_event", {30'd0, code_upd, period_err}, 0);
            end else begin
                ev_t e;
                e = q.pop_front();
                check("code_upd", code_upd, (e.kind != 1) ? 1 : 0);
                check("period_err", period_err, (e.kind == 1) ? 1 : 0);
                check("speed_code", speed_code, e.code);
                check("code_valid", code_valid, e.valid);
                if (e.kind == 0) begin
                    check("high_cnt", high_cnt, e.hcnt);
                    check("stuck_clr", stuck_fault, 0);
                end
            end
        end
    end

    initial begin
        int p, h;
        tbl[0]  = '{32, 64, 4, 1'b0};
        tbl[1]  = '{32, 64, 4, 1'b0};
        tbl[2]  = '{32, 64, 4, 1'b0};
        tbl[3]  = '{27, 64, 3, 1'b0};
        tbl[4]  = '{28, 64, 4, 1'b0};
        tbl[5]  = '{3,  64, 0, 1'b0};
        tbl[6]  = '{52, 64, 7, 1'b0};
        tbl[7]  = '{51, 64, 6, 1'b0};
        tbl[8]  = '{32, 72, 0, 1'b1};
        tbl[9]  = '{32, 68, 4, 1'b0};
        tbl[10] = '{32, 60, 4, 1'b0};
        tbl[11] = '{32, 59, 0, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_speed_code", speed_code, 0);
        check("rst_code_valid", code_valid, 0);
        check("rst_code_upd", code_upd, 0);
        check("rst_high_cnt", high_cnt, 0);
        check("rst_period_err", period_err, 0);
        check("rst_stuck", stuck_fault, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        foreach (tbl[i]) drive_period(tbl[i].h, tbl[i].p, tbl[i].exp_code, tbl[i].exp_err);
        for (int i = 0; i < 30; i++) begin
            p = $urandom_range(76, 56);
            h = $urandom_range(p - 1, 1);
            drive_period(h, p, ref_code(h), ref_err(p));
        end
        pwm_in = 1'b1;
        drain(20);

        // Line stuck high
        repeat (300) @(negedge clk);
        m_valid = 0;
        model_clear_cand();
        check("stuck_set", stuck_fault, 1);
        check("stuck_invalid", code_valid, 0);

        // Line low for a full timeout: motor stopped
        pwm_in = 1'b0;
        m_code = 0;
        m_valid = 1;
        model_clear_cand();
        q.push_back('{2, 0, 1, 0});
        drain(320);
        check("stuck_kept", stuck_fault, 1);

        drive_period(32, 64, 4, 1'b0);
        drive_period(32, 64, 4, 1'b0);
        pwm_in = 1'b1;
        drain(20);
        check("stuck_cleared", stuck_fault, 0);

        // fault_in mid-stream
        fault_in = 1'b1;
        @(negedge clk);
        check("fault_invalid", code_valid, 0);
        m_valid = 0;
        model_clear_cand();
        repeat (3) raw_period(16, 32);
        repeat (3) @(negedge clk);
        check("fault_code_held", speed_code, m_code);
        check("fault_hcnt_held", high_cnt, m_hcnt);
        check("fault_still_invalid", code_valid, 0);
        fault_in = 1'b0;
        repeat (4) @(negedge clk);
        drive_period(32, 64, 4, 1'b0);
        drive_period(40, 64, 5, 1'b0);
        pwm_in = 1'b1;
        drain(20);

        // Reset in the middle of a high phase
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_speed_code", speed_code, 0);
        check("mid_rst_code_valid", code_valid, 0);
        check("mid_rst_code_upd", code_upd, 0);
        check("mid_rst_high_cnt", high_cnt, 0);
        check("mid_rst_period_err", period_err, 0);
        check("mid_rst_stuck", stuck_fault, 0);
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_code = 0;
        m_valid = 0;
        m_hcnt = 0;
        model_clear_cand();
        repeat (4) @(negedge clk);

        // 4, 5, 5: with the filter only the second 5 commits
        drive_period(32, 64, 4, 1'b0);
        drive_period(40, 64, 5, 1'b0);
        drive_period(40, 64, 5, 1'b0);
        pwm_in = 1'b1;
        drain(20);
        check("final_code", speed_code, 5);
        check("final_valid", code_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
